// File: rtl/mode_toggle_arbiter_pkg.sv
// mode_toggle_arbiter_pkg: shared widths, mode codes, hold-off default and gesture states
package mode_toggle_arbiter_pkg;
    localparam int DEF_MODE_WIDTH = 3;
    localparam int DEF_MAX_WIDTH = 32;
    localparam int TOGGLE_HOLDOFF = 16;
    typedef enum logic [DEF_MODE_WIDTH-1:0] {
        OFF_MODE, FIRST_MODE, SECOND_MODE, THIRD_MODE,
        FOURTH_MODE, FIFTH_MODE, SIXTH_MODE, SET_MODE
    } mode_e;
    typedef enum logic {G_IDLE, G_ARMED} gest_state_e;
endpackage

// File: rtl/mode_toggle_arbiter_gesture_seq_detector.sv
// gesture_seq_detector: first-then-second gesture within a window, cancelled by mode change
module gesture_seq_detector
    import mode_toggle_arbiter_pkg::*;
#(
    parameter int MODE_WIDTH = DEF_MODE_WIDTH,
    parameter int NUM_MODES = 2 ** MODE_WIDTH,
    parameter int WIN_WIDTH = DEF_MAX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [MODE_WIDTH-1:0] current_mode,
    input  logic                  gest_first,
    input  logic                  gest_second,
    input  logic [NUM_MODES-1:0]  gest_mode_mask,
    input  logic [WIN_WIDTH-1:0]  gest_window,
    input  logic                  block,
    output logic                  gest_hit,
    output logic                  gest_armed
);
    gest_state_e           state_q, state_d;
    logic                  first_q, second_q;
    logic [MODE_WIDTH-1:0] mode_q;
    logic [WIN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIN_WIDTH:0]    elapsed;
    logic                  first_rise, second_rise, mode_ok, mode_chg, arm_ok, in_win;

    assign first_rise = gest_first & ~first_q;
    assign second_rise = gest_second & ~second_q;
    assign mode_ok = 32'(current_mode) < NUM_MODES;
    assign mode_chg = current_mode != mode_q;
    assign arm_ok = mode_ok && gest_mode_mask[current_mode] && !block;
    // cnt_q holds cycles since the arming edge minus one, so elapsed is the true distance
    assign elapsed = {1'b0, cnt_q} + {{WIN_WIDTH{1'b0}}, 1'b1};
    assign in_win = elapsed < {1'b0, gest_window};
    assign gest_armed = state_q == G_ARMED;

    // Edge history, registered mode copy, FSM state and window counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= G_IDLE;
            first_q <= 1'b0;
            second_q <= 1'b0;
            mode_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= gest_first;
            second_q <= gest_second;
            mode_q <= current_mode;
            cnt_q <= cnt_d;
        end
    end

    // Next state: cancel on mode change, hit inside window, restart on re-edge, else time out
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        gest_hit = 1'b0;
        if (state_q == G_IDLE) begin
            state_d = first_rise && arm_ok ? G_ARMED : G_IDLE;
            cnt_d = '0;
        end else if (mode_chg) begin
            state_d = G_IDLE;
        end else if (second_rise && in_win) begin
            gest_hit = 1'b1;
            state_d = G_IDLE;
        end else if (first_rise) begin
            cnt_d = '0;
        end else if (!in_win) begin
            state_d = G_IDLE;
        end else begin
            cnt_d = elapsed[WIN_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/mode_toggle_arbiter.sv
// mode_toggle_arbiter: masked, prioritised, held-off toggle pulse from sources and a gesture
module mode_toggle_arbiter
    import mode_toggle_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int MODE_WIDTH = DEF_MODE_WIDTH,
    parameter int NUM_MODES = 2 ** MODE_WIDTH,
    parameter int WIN_WIDTH = DEF_MAX_WIDTH,
    parameter int HOLDOFF_CYCLES = TOGGLE_HOLDOFF
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [MODE_WIDTH-1:0]          current_mode,
    input  logic [NUM_SRC-1:0]             src_req,
    input  logic [NUM_SRC*NUM_MODES-1:0]   src_mode_mask,
    input  logic                           gest_first,
    input  logic                           gest_second,
    input  logic [NUM_MODES-1:0]           gest_mode_mask,
    input  logic [WIN_WIDTH-1:0]           gest_window,
    output logic                           toggle,
    output logic [$clog2(NUM_SRC+1)-1:0]   toggle_src,
    output logic                           holdoff_busy,
    output logic                           gest_armed
);
    localparam int SRC_W = $clog2(NUM_SRC + 1);
    localparam int HW = HOLDOFF_CYCLES > 0 ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    logic [NUM_SRC-1:0] src_req_q, rise, qreq;
    logic               started_q, toggle_q, toggle_d, gest_hit, mode_ok;
    logic [SRC_W-1:0]   toggle_src_q, toggle_src_d, win;
    logic [HW-1:0]      hold_q, hold_d;

    assign rise = src_req & ~src_req_q;
    assign mode_ok = 32'(current_mode) < NUM_MODES;
    assign holdoff_busy = |hold_q;
    assign toggle = toggle_q;
    assign toggle_src = toggle_src_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_qreq
        logic [NUM_MODES-1:0] row;
        assign row = src_mode_mask[s*NUM_MODES +: NUM_MODES];
        assign qreq[s] = rise[s] & mode_ok & row[current_mode] & ~holdoff_busy & started_q;
    end

    gesture_seq_detector #(
        .MODE_WIDTH(MODE_WIDTH),
        .NUM_MODES (NUM_MODES),
        .WIN_WIDTH (WIN_WIDTH)
    ) u_gest (
        .clk           (clk),
        .rstn          (rstn),
        .current_mode  (current_mode),
        .gest_first    (gest_first),
        .gest_second   (gest_second),
        .gest_mode_mask(gest_mode_mask),
        .gest_window   (gest_window),
        .block         (holdoff_busy | ~started_q),
        .gest_hit      (gest_hit),
        .gest_armed    (gest_armed)
    );

    // Request history, first-cycle suppression, toggle pulse, winner and hold-off counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_req_q <= '0;
            started_q <= 1'b0;
            toggle_q <= 1'b0;
            toggle_src_q <= '0;
            hold_q <= '0;
        end else begin
            src_req_q <= src_req;
            started_q <= 1'b1;
            toggle_q <= toggle_d;
            toggle_src_q <= toggle_src_d;
            hold_q <= hold_d;
        end
    end

    // Lowest index wins, gesture last; losers are dropped and hold-off reloads on every pulse
    always_comb begin
        win = SRC_W'(NUM_SRC);
        for (int i = NUM_SRC - 1; i >= 0; i--)
            win = qreq[i] ? SRC_W'(i) : win;
        toggle_d = |qreq | gest_hit;
        toggle_src_d = toggle_d ? win : toggle_src_q;
        hold_d = toggle_d ? HW'(HOLDOFF_CYCLES) : (holdoff_busy ? hold_q - HW'(1) : hold_q);
    end
endmodule

// File: tb/tb_mode_toggle_arbiter.sv
// tb_mode_toggle_arbiter: directed checks of masking, priority, hold-off, gesture and reset
module tb_mode_toggle_arbiter;
    import mode_toggle_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  current_mode = '0;
    logic [3:0]  src_req = '0;
    logic [31:0] src_mode_mask = {8'h04, 8'hFF, 8'hFF, 8'hFF};
    logic        gest_first = 1'b0;
    logic        gest_second = 1'b0;
    logic [7:0]  gest_mode_mask = 8'hFF;
    logic [31:0] gest_window = 32'd100;
    logic        toggle;
    logic [2:0]  toggle_src;
    logic        holdoff_busy;
    logic        gest_armed;
    int          n_tests = 0;
    int          n_fail = 0;
    int          p;

    mode_toggle_arbiter dut (
        .clk           (clk),
        .rstn          (rstn),
        .current_mode  (current_mode),
        .src_req       (src_req),
        .src_mode_mask (src_mode_mask),
        .gest_first    (gest_first),
        .gest_second   (gest_second),
        .gest_mode_mask(gest_mode_mask),
        .gest_window   (gest_window),
        .toggle        (toggle),
        .toggle_src    (toggle_src),
        .holdoff_busy  (holdoff_busy),
        .gest_armed    (gest_armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            pulses += int'(toggle);
        end
    endtask

    task automatic gesture(input int gap);
        gest_first = 1'b1;
        tick();
        gest_first = 1'b0;
        repeat (gap - 1) tick();
        gest_second = 1'b1;
        tick();
    endtask

    initial begin
        #1;
        check("rst_toggle", 32'(toggle), 0);
        check("rst_src", 32'(toggle_src), 0);
        check("rst_busy", 32'(holdoff_busy), 0);
        check("rst_armed", 32'(gest_armed), 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (3) tick();

        current_mode = OFF_MODE;
        src_req[0] = 1'b1;
        tick();
        check("t1_toggle", 32'(toggle), 1);
        check("t1_src", 32'(toggle_src), 0);
        check("t1_busy_start", 32'(holdoff_busy), 1);
        tick();
        check("t1_one_cycle", 32'(toggle), 0);
        repeat (14) tick();
        check("t1_busy_last", 32'(holdoff_busy), 1);
        tick();
        check("t1_busy_clear", 32'(holdoff_busy), 0);
        watch(5, p);
        check("t1_held_no_repeat", 32'(p), 0);

        src_req = '0;
        tick();
        src_req = 4'b0110;
        tick();
        check("t2_toggle", 32'(toggle), 1);
        check("t2_src", 32'(toggle_src), 1);
        watch(30, p);
        check("t2_src2_dropped", 32'(p), 0);

        src_req = '0;
        current_mode = FIRST_MODE;
        tick();
        src_req[3] = 1'b1;
        watch(3, p);
        check("t3_masked", 32'(p), 0);
        src_req = '0;
        current_mode = SECOND_MODE;
        tick();
        src_req[3] = 1'b1;
        tick();
        check("t3_toggle", 32'(toggle), 1);
        check("t3_src", 32'(toggle_src), 3);
        src_req = '0;
        current_mode = OFF_MODE;
        repeat (20) tick();

        gesture(50);
        check("t4_hit", 32'(toggle), 1);
        check("t4_hit_src", 32'(toggle_src), 4);
        check("t4_hit_disarm", 32'(gest_armed), 0);
        gest_second = 1'b0;
        repeat (20) tick();
        gesture(99);
        check("t4_edge99_hit", 32'(toggle), 1);
        gest_second = 1'b0;
        repeat (20) tick();
        gest_first = 1'b1;
        tick();
        gest_first = 1'b0;
        repeat (99) tick();
        check("t4_armed_t99", 32'(gest_armed), 1);
        gest_second = 1'b1;
        tick();
        check("t4_timeout_no_toggle", 32'(toggle), 0);
        check("t4_timeout_disarm", 32'(gest_armed), 0);
        gest_second = 1'b0;
        tick();

        gest_first = 1'b1;
        tick();
        gest_first = 1'b0;
        repeat (19) tick();
        check("t5_armed", 32'(gest_armed), 1);
        current_mode = FIRST_MODE;
        tick();
        check("t5_cancel", 32'(gest_armed), 0);
        tick();
        gest_second = 1'b1;
        watch(3, p);
        check("t5_no_toggle", 32'(p), 0);
        gest_second = 1'b0;
        current_mode = OFF_MODE;
        gest_window = '0;
        tick();
        gesture(1);
        check("t5_win0_no_toggle", 32'(toggle), 0);
        gest_second = 1'b0;
        gest_window = 32'd100;
        repeat (3) tick();

        src_req[0] = 1'b1;
        tick();
        check("t6_toggle", 32'(toggle), 1);
        src_req[0] = 1'b0;
        tick();
        src_req[0] = 1'b1;
        watch(3, p);
        check("t6_holdoff_ignored", 32'(p), 0);
        check("t6_busy", 32'(holdoff_busy), 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_toggle", 32'(toggle), 0);
        check("t6_rst_busy", 32'(holdoff_busy), 0);
        check("t6_rst_src", 32'(toggle_src), 0);
        tick();
        rstn = 1'b1;
        watch(6, p);
        check("t6_no_fire_after_rst", 32'(p), 0);
        src_req[0] = 1'b0;
        tick();
        src_req[0] = 1'b1;
        tick();
        check("t6_refire", 32'(toggle), 1);
        check("t6_refire_src", 32'(toggle_src), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mode_toggle_arbiter.md
Name: mode_toggle_arbiter

Overview:
- Parametrised successor to the per-mode toggle generators.
- One instance arbitrates NUM_SRC request sources plus one two-step gesture sequence, and produces a single registered toggle pulse toward one target mode.
- Each source's legality per current mode comes from a runtime mask, not fixed case logic.
- Adds priority reporting, a post-toggle hold-off, and gesture cancellation on mode change.

Parameters:
- NUM_SRC, 4, number of level request sources (debounced buttons, menu, etc.).
- MODE_WIDTH, 3, width of the mode code; must equal `MODE_WIDTH.
- NUM_MODES, 8, number of mode codes (2**MODE_WIDTH).
- WIN_WIDTH, 32, width of the gesture window count (`MAX_WIDTH).
- HOLDOFF_CYCLES, 16, cycles of request blanking after each toggle; 0 disables hold-off.

Ports:
- clk  in  1  100 MHz clock
- rstn  in  1  asynchronous, active-low reset
- current_mode  in  MODE_WIDTH  current system mode code
- src_req  in  NUM_SRC  level requests, already debounced
- src_mode_mask  in  NUM_SRC*NUM_MODES  bit [s*NUM_MODES+m] = source s allowed in mode m
- gest_first  in  1  first gesture level (e.g. left)
- gest_second  in  1  second gesture level (e.g. right)
- gest_mode_mask  in  NUM_MODES  modes in which a gesture sequence is allowed
- gest_window  in  WIN_WIDTH  maximum cycles from first to second gesture
- toggle  out  1  one-cycle toggle pulse
- toggle_src  out  $clog2(NUM_SRC+1)  winner index, valid with toggle; NUM_SRC = gesture
- holdoff_busy  out  1  high while blanking
- gest_armed  out  1  high while waiting for the second gesture

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk, rising edge.
- On reset, all outputs are 0, edge history registers are 0, the gesture FSM is IDLE, and the hold-off counter is 0.
- Edge detect: rise[s] = src_req[s] & ~src_req_q[s]. src_req_q updates every cycle, including during hold-off.
- Qualified request: qreq[s] = rise[s] & src_mode_mask[s*NUM_MODES+current_mode] & ~holdoff_busy.
- Gesture FSM (sub-module), states IDLE and ARMED:
  - IDLE -> ARMED on a rising edge of gest_first when gest_mode_mask[current_mode]=1 and holdoff_busy=0; the window counter loads 0.
  - In ARMED, the counter increments each cycle.
  - A rising edge of gest_second while counter < gest_window emits gest_hit for 1 cycle and returns to IDLE.
  - counter == gest_window -> IDLE with no hit.
  - A change of current_mode (versus the registered copy) -> IDLE, no hit.
  - A gest_first re-edge while ARMED restarts the counter at 0.
  - gest_window = 0 means no sequence can ever complete.
  - gest_armed = (state == ARMED).
- Arbitration: fixed priority, lowest source index wins; gest_hit is the lowest-priority candidate (index NUM_SRC). Losing simultaneous edges are dropped, not queued.
- Latency: if any candidate is present in cycle n, toggle=1 and toggle_src=winner in cycle n+1, for exactly one cycle. toggle_src holds its last value otherwise.
- Hold-off: the cycle toggle is asserted, the counter loads HOLDOFF_CYCLES and holdoff_busy=1. The counter decrements each cycle, and holdoff_busy clears when it reaches 0. Total blanked edge cycles = HOLDOFF_CYCLES, counted from the toggle cycle.
- Source held high: no repeat toggle without a new low->high transition.
- Mode code outside NUM_MODES: all masks index as 0, so no toggle.
- Reset asserted mid-pulse or mid-hold-off: everything clears immediately. After release, a src_req already high does not fire, because src_req_q resets to 0 and captures the level in the first cycle. The first post-reset cycle is explicitly suppressed.

Decomposition:
- Shared header parameters.vh: `MODE_WIDTH, `MAX_WIDTH, mode codes (`OFF_MODE ... `SET_MODE).
- Add `TOGGLE_HOLDOFF default macro to the same header.
- One sub-module: gesture_seq_detector (IDLE/ARMED FSM, window counter, edge detectors, mode-change cancel).
- Edge detect, masking, priority encoder and hold-off stay in the top module.

Test Plan:
1. current_mode=OFF, mask allows src0 in OFF; src_req[0] rises at cycle 10 -> toggle=1 at cycle 11 only, toggle_src=0, holdoff_busy high through cycle 26 (HOLDOFF_CYCLES=16).
2. src_req[1] and src_req[2] rise in the same cycle, both allowed -> one pulse, toggle_src=1; no pulse for src2 afterwards.
3. Source 3 masked off in FIRST_MODE, rises -> no toggle. Switch mode to SECOND (allowed), re-pulse -> toggle with toggle_src=3.
4. gest_window=100: first at t, second at t+50 -> toggle_src=NUM_SRC one cycle after the second edge. Repeat with second at t+100 -> no toggle, gest_armed drops at t+101.
5. Gesture armed, current_mode changes at t+20 -> gest_armed=0 next cycle; a later gest_second edge produces no toggle.
6. src0 edge during hold-off -> ignored. Reset pulse while holdoff_busy=1 with src0 held high -> all outputs 0, no toggle after release until src0 toggles low then high.
